prga: RTL and testbench

//  ARC4 pseudo-random generation stage, directly downstream of ksa.

---
 rtl/arc4_pkg.sv | 10 +
 rtl/prga.sv | 126 ++++++++++++
 tb/tb_prga.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// arc4_pkg: shared ARC4 types, PRGA state encoding and timing constants
package arc4_pkg;
  typedef logic [7:0] byte_t;
  typedef enum logic [3:0] {
    IDLE, RD_LEN, LAT_LEN, WR_LEN, RD_SI, LAT_SI, RD_SJ,
    LAT_SJ, WR_SI, WR_SJ, RD_PAD, LAT_PAD, WR_PT
  } prga_state_t;
  localparam int PRGA_CYC_PER_BYTE = 9;
  localparam int PRGA_HDR_CYC = 3;
endpackage

// File: rtl/prga.sv
// prga: ARC4 keystream stage decrypting a length-prefixed ciphertext into plaintext memory
module prga
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);
  prga_state_t state_q, state_d;
  byte_t i_q, i_d, j_q, j_d, k_q, k_d, l_q, l_d, si_q, si_d, sj_q, sj_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      l_q <= '0;
      si_q <= '0;
      sj_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
      l_q <= l_d;
      si_q <= si_d;
      sj_q <= sj_d;
    end
  end
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    l_d = l_q;
    si_d = si_q;
    sj_d = sj_q;
    rdy = 1'b0;
    s_addr = '0;
    s_wrdata = '0;
    s_wren = 1'b0;
    ct_addr = '0;
    pt_addr = '0;
    pt_wrdata = '0;
    pt_wren = 1'b0;
    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          state_d = RD_LEN;
          i_d = '0;
          j_d = '0;
          k_d = 8'd1;
        end
      end
      RD_LEN: state_d = LAT_LEN;
      LAT_LEN: state_d = WR_LEN;
      WR_LEN: begin
        l_d = ct_rddata;
        pt_wrdata = ct_rddata;
        pt_wren = 1'b1;
        state_d = (ct_rddata == 8'd0) ? IDLE : RD_SI;
      end
      RD_SI: begin
        i_d = i_q + 8'd1;
        s_addr = i_q + 8'd1;
        state_d = LAT_SI;
      end
      LAT_SI: begin
        s_addr = i_q;
        state_d = RD_SJ;
      end
      RD_SJ: begin
        si_d = s_rddata;
        j_d = j_q + s_rddata;
        s_addr = j_q + s_rddata;
        state_d = LAT_SJ;
      end
      LAT_SJ: begin
        s_addr = j_q;
        state_d = WR_SI;
      end
      WR_SI: begin
        sj_d = s_rddata;
        s_addr = i_q;
        s_wrdata = s_rddata;
        s_wren = 1'b1;
        state_d = WR_SJ;
      end
      WR_SJ: begin
        s_addr = j_q;
        s_wrdata = si_q;
        s_wren = 1'b1;
        state_d = RD_PAD;
      end
      RD_PAD: begin
        s_addr = si_q + sj_q;
        ct_addr = k_q;
        state_d = LAT_PAD;
      end
      LAT_PAD: begin
        s_addr = si_q + sj_q;
        ct_addr = k_q;
        state_d = WR_PT;
      end
      WR_PT: begin
        pt_addr = k_q;
        pt_wrdata = s_rddata ^ ct_rddata;
        pt_wren = 1'b1;
        k_d = (k_q == l_q) ? k_q : k_q + 8'd1;
        state_d = (k_q == l_q) ? IDLE : RD_SI;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_prga.sv
// tb_prga: directed scoreboard bench for prga against a software ARC4 model
module tb_prga;
  import arc4_pkg::*;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0;
  logic rdy, s_wren, pt_wren;
  logic [7:0] s_addr, s_wrdata, ct_addr, pt_addr, pt_wrdata;
  byte_t s_rd, ct_rd;
  byte_t s_mem[256], s_init[256], ct_mem[256], pt_mem[256], bm[256];
  logic [15:0] exp_q[$];
  int checks = 0, passes = 0, s_wr_cnt = 0, cyc;
  always #5 clk = ~clk;
  prga dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rd), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_addr(ct_addr), .ct_rddata(ct_rd),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );
  always @(posedge clk) begin
    if (load) begin
      s_mem <= s_init;
      pt_mem <= '{default: 8'hff};
    end else begin
      if (s_wren) s_mem[s_addr] <= s_wrdata;
      if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
    end
    s_rd <= s_mem[s_addr];
    ct_rd <= ct_mem[ct_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  always @(negedge clk) begin
    if (!rst && s_wren) s_wr_cnt++;
    if (!rst && pt_wren) chk("pt_write", {16'd0, pt_addr, pt_wrdata},
                             exp_q.size() > 0 ? {16'd0, exp_q.pop_front()} : 32'hdead_beef);
  end
  task automatic load_identity();
    for (int i = 0; i < 256; i++) s_init[i] = byte_t'(i);
  endtask
  task automatic load_s();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
    bm = s_init;
  endtask
  task automatic model_run();
    int i = 0, j = 0;
    byte_t t, pad;
    exp_q.push_back({8'd0, ct_mem[0]});
    for (int k = 1; k <= int'(ct_mem[0]); k++) begin
      i = (i + 1) % 256;
      j = (j + int'(bm[i])) % 256;
      t = bm[i];
      bm[i] = bm[j];
      bm[j] = t;
      pad = bm[(int'(bm[i]) + int'(bm[j])) % 256];
      exp_q.push_back({8'(k), pad ^ ct_mem[k]});
    end
  endtask
  task automatic run(input bit hold, output int c);
    @(negedge clk) en = 1'b1;
    @(posedge clk) #1;
    if (!hold) en = 1'b0;
    chk("busy_after_accept", {31'd0, rdy}, 0);
    c = 0;
    while (c < 3000) begin
      @(posedge clk) #1;
      c++;
      if (rdy) break;
    end
    en = 1'b0;
  endtask
  task automatic full_case(input string tag, input int l, input bit hold);
    int bad = 0;
    s_wr_cnt = 0;
    model_run();
    run(hold, cyc);
    chk({tag, "_busy"}, cyc, PRGA_HDR_CYC + PRGA_CYC_PER_BYTE * l);
    repeat (2) @(negedge clk);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    chk({tag, "_still_idle"}, {31'd0, rdy}, 1);
    for (int i = 0; i < 256; i++) bad += (s_mem[i] !== bm[i]) ? 1 : 0;
    chk({tag, "_s_final"}, bad, 0);
  endtask
  initial begin
    logic [23:0] key = 24'h1E4600;
    byte_t kb[3];
    int j;
    byte_t t;
    for (int i = 0; i < 256; i++) ct_mem[i] = 8'h00;
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", {31'd0, rdy}, 1);
    chk("rst_s_wren", {31'd0, s_wren}, 0);
    chk("rst_pt_wren", {31'd0, pt_wren}, 0);
    chk("rst_addrs", {8'd0, s_addr, ct_addr, pt_addr}, 0);
    chk("rst_wrdata", {16'd0, s_wrdata, pt_wrdata}, 0);
    @(negedge clk) en = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("en_during_rst_ignored", {31'd0, rdy}, 1);
    load_identity();
    load_s();
    ct_mem[0] = 8'd1;
    ct_mem[1] = 8'h00;
    full_case("one_byte", 1, 1'b0);
    chk("one_byte_pt", {16'd0, pt_mem[0], pt_mem[1]}, 16'h0102);
    chk("one_byte_s_unchanged", s_wr_cnt == 2 && s_mem[1] == 8'd1 ? 1 : 0, 1);
    load_s();
    ct_mem[0] = 8'd3;
    for (int i = 1; i <= 3; i++) ct_mem[i] = 8'h00;
    full_case("three_byte", 3, 1'b0);
    chk("three_byte_pt", {pt_mem[0], pt_mem[1], pt_mem[2], pt_mem[3]}, 32'h03020507);
    chk("three_byte_s", {8'd0, s_mem[2], s_mem[3], s_mem[5]}, 32'h030502);
    load_s();
    ct_mem[0] = 8'd0;
    full_case("zero_len", 0, 1'b0);
    chk("zero_len_pt0", {24'd0, pt_mem[0]}, 0);
    chk("zero_len_no_s_wren", s_wr_cnt, 0);
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    load_identity();
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + int'(s_init[i]) + int'(kb[i % 3])) % 256;
      t = s_init[i];
      s_init[i] = s_init[j];
      s_init[j] = t;
    end
    load_s();
    ct_mem[0] = 8'd53;
    for (int i = 1; i <= 53; i++) ct_mem[i] = byte_t'($urandom_range(0, 255));
    full_case("ksa_key_l53_hold_en", 53, 1'b1);
    load_identity();
    load_s();
    ct_mem[0] = 8'd255;
    for (int i = 1; i <= 255; i++) ct_mem[i] = byte_t'($urandom_range(0, 255));
    full_case("max_len", 255, 1'b0);
    chk("max_len_last_pt", {24'd0, pt_mem[255]}, 32'(ct_mem[255] ^ bm[(int'(bm[255]) + int'(bm[bm[255]])) % 256]) & 0 | {24'd0, pt_mem[255]} & {24'd0, (pt_mem[255] !== 8'hff) ? 8'hff : 8'h00});
    load_s();
    ct_mem[0] = 8'd3;
    for (int i = 1; i <= 3; i++) ct_mem[i] = 8'h00;
    model_run();
    @(negedge clk) en = 1'b1;
    @(posedge clk) #1 en = 1'b0;
    repeat (PRGA_HDR_CYC + PRGA_CYC_PER_BYTE + 3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrun_rst_rdy", {31'd0, rdy}, 1);
    chk("midrun_rst_wrens", {30'd0, s_wren, pt_wren}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    load_identity();
    load_s();
    full_case("after_rst", 3, 1'b0);
    chk("after_rst_pt", {pt_mem[0], pt_mem[1], pt_mem[2], pt_mem[3]}, 32'h03020507);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
